mem_access_unit: RTL

Memory-stage load/store unit. It sits between the EX/MEM and MEM/WB pipeline registers and drives a variable-latency data-memory bus with a req/ack handshake. It performs store byte-lane alignment and load sign/zero extension. Data_Out_Ext_M is driven from a register, so the MEM/WB register can pass it straight through to writeback without another flop.

---
 rtl/mem_access_unit_pkg.sv | 32 +++
 rtl/mem_access_unit_load_extender.sv | 33 +++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store unit: FSM states,
// funct3 access codes and the access-size decoder.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mau_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  // Unused funct3 codes fall through to word size.
  function automatic acc_size_t access_size(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Combinational load lane selection and sign/zero extension of read data.
module mem_access_unit_load_extender
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  ext_data = {24'h0, byte_sel};
      F3_LHU:  ext_data = {16'h0, half_sel};
      F3_LW:   ext_data = rdata;
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit driving a req/ack data bus with timeout.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_R_En_M,
  input  logic        MEM_W_En_M,
  input  logic [2:0]  Funct3_M,
  input  logic [31:0] ALU_Out_M,
  input  logic [31:0] Store_Data_M,
  input  logic        Hold_M,
  output logic        DMEM_Req,
  output logic        DMEM_We,
  output logic [31:0] DMEM_Addr,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WData,
  input  logic [31:0] DMEM_RData,
  input  logic        DMEM_Ack,
  output logic        Stall_M,
  output logic [31:0] Data_Out_Ext_M,
  output logic        Bus_Err_M,
  output logic        Misalign_M,
  output mau_state_t  State_Dbg_M
);

  // Handshake: DMEM_Req stays high with stable address/data until the cycle
  // DMEM_Ack is seen (possibly the first one) or the wait counter expires.
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  mau_state_t  state;
  logic [CW-1:0] cnt;
  logic [31:0] load_buf;
  logic [31:0] ext_data;
  acc_size_t   acc_size;
  logic        mem_en;
  logic        misalign_raw;
  logic        access;
  logic        timeout;

  assign acc_size = access_size(Funct3_M);
  assign mem_en   = MEM_R_En_M | MEM_W_En_M;

`ifdef MISALIGN_TRAP_EN
  assign misalign_raw = mem_en &
                        (((acc_size == SZ_HALF) & ALU_Out_M[0]) |
                         ((acc_size == SZ_WORD) & (ALU_Out_M[1:0] != 2'b00)));
`else
  assign misalign_raw = 1'b0;
`endif

  assign access     = mem_en & ~misalign_raw;
  assign Misalign_M = ~RST & misalign_raw;

  // Ack in the last counted cycle still completes the access.
  assign timeout = (state == ST_WAIT) & ~DMEM_Ack & (cnt == CNT_LAST);

  assign DMEM_Req  = ~RST & (((state == ST_IDLE) & access) | (state == ST_WAIT));
  assign DMEM_We   = MEM_W_En_M & DMEM_Req;
  assign DMEM_Addr = {ALU_Out_M[31:2], 2'b00};
  assign Stall_M   = ~RST & (((state == ST_IDLE) & access & ~DMEM_Ack) |
                             ((state == ST_WAIT) & ~DMEM_Ack & ~timeout));
  assign Bus_Err_M = ~RST & timeout;
  assign State_Dbg_M = state;

  always_comb begin
    case (acc_size)
      SZ_BYTE: begin
        DMEM_BE    = 4'b0001 << ALU_Out_M[1:0];
        DMEM_WData = {4{Store_Data_M[7:0]}};
      end
      SZ_HALF: begin
        DMEM_BE    = 4'b0011 << {ALU_Out_M[1], 1'b0};
        DMEM_WData = {2{Store_Data_M[15:0]}};
      end
      default: begin
        DMEM_BE    = 4'b1111;
        DMEM_WData = Store_Data_M;
      end
    endcase
  end

  mem_access_unit_load_extender u_load_extender (
    .rdata    (DMEM_RData),
    .addr     (ALU_Out_M[1:0]),
    .funct3   (Funct3_M),
    .ext_data (ext_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      load_buf       <= '0;
      Data_Out_Ext_M <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_WAIT: begin
          if ((state == ST_WAIT) || access) begin
            if (DMEM_Ack) begin
              cnt <= '0;
              // A held pipeline parks the load result until the hold lifts.
              if (Hold_M) begin
                state <= ST_DONE;
                if (MEM_R_En_M) load_buf <= ext_data;
              end else begin
                state <= ST_IDLE;
                if (MEM_R_En_M) Data_Out_Ext_M <= ext_data;
              end
            end else if (state == ST_IDLE) begin
              state <= ST_WAIT;
              cnt   <= CW'(1);
            end else if (cnt == CNT_LAST) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_DONE: begin
          if (!Hold_M) begin
            if (MEM_R_En_M) Data_Out_Ext_M <= load_buf;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
